pipe_stage_tracker: RTL
=======================

Name: pipe_stage_tracker

Overview:
- Pipeline-register side of the stage-control interface for the 5-stage MIPS CPU.
- Consumes the per-stage rst/en pairs driven by the pipeline controller.
- Returns the stage valid flags and the per-stage hazard feedback the controller uses for forwarding and stall decisions (register write address, write enable, load/store flags).
- Also keeps cycle, retired-instruction and bubble counters for debug readout.

Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  main clock
- rst_n  in  1  asynchronous active-low reset
- if_rst, if_en  in  1 each  IF stage reset/enable from controller
- id_rst, id_en  in  1 each  ID stage reset/enable
- exe_rst, exe_en  in  1 each  EXE stage reset/enable
- mem_rst, mem_en  in  1 each  MEM stage reset/enable
- wb_rst, wb_en  in  1 each  WB stage reset/enable
- regw_addr_id  in  5  destination register decoded in ID
- wb_wen_id  in  1  register write enable decoded in ID
- is_load_id  in  1  ID instruction is LW
- is_store_id  in  1  ID instruction is SW
- addr_rt_id  in  5  RT field of ID instruction
- cnt_clr  in  1  synchronous clear of all counters
- if_valid, id_valid, exe_valid, mem_valid, wb_valid  out  1 each  stage holds a real instruction
- regw_addr_exe, wb_wen_exe, is_load_exe, is_store_exe  out  5/1/1/1  EXE feedback
- regw_addr_mem, wb_wen_mem, is_load_mem, is_store_mem, addr_rt_mem  out  5/1/1/1/5  MEM feedback
- regw_addr_wb, wb_wen_wb  out  5/1  WB feedback
- cycle_cnt, retire_cnt, bubble_cnt  out  CNT_W each  performance counters

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (rst_n). While rst_n=0, every output is 0.
- Stage update rule, per stage X, at posedge clk:
  - X_rst=1: load bubble (valid=0, all fields 0). X_rst has priority over X_en.
  - Else X_en=1: load from the upstream stage.
  - Else: hold.
- IF: if_valid loads constant 1 (fetch always yields an instruction once out of reset).
- ID: id_valid loads if_valid.
- EXE loads:
  - exe_valid <= id_valid
  - regw_addr_exe <= regw_addr_id
  - addr_rt carried internally <= addr_rt_id
  - wb_wen_exe <= wb_wen_id & id_valid
  - is_load_exe <= is_load_id & id_valid
  - is_store_exe <= is_store_id & id_valid
  - Invalid slots therefore never advertise a write or a load.
- MEM loads all EXE fields, including addr_rt → addr_rt_mem.
- WB loads mem_valid, regw_addr_mem and wb_wen_mem.
- Latency: ID fields are visible on the EXE outputs 1 cycle after the edge, MEM 2 cycles, WB 3 cycles, provided each stage is enabled.
- Load-use stall (controller drives if_en=0, id_en=0, exe_rst=1):
  - IF and ID hold.
  - EXE becomes a bubble.
  - MEM and WB advance normally.
- Debug freeze (all en=0, all rst=0): every register holds, including the counters.
- Counters, all updated at posedge clk, in this priority order:
  - cnt_clr=1: all counters load 0 (overrides every increment).
  - cycle_cnt: +1 on each edge where wb_en=1.
  - retire_cnt: +1 on each edge where wb_valid=1, wb_en=1 and wb_rst=0 (the instruction leaving WB).
  - bubble_cnt: +1 on each edge where exe_rst=1 and mem_rst=0 (stall bubble, not a global reset).
  - All counters wrap modulo 2^CNT_W with no saturation.
- Reset mid-operation: asserting rst_n low asynchronously clears every stage and counter in the same cycle with no clock needed. The first edge after release behaves as in-reset for no stage, i.e. normal rules apply.
- Simultaneous events:
  - A stage with rst=1 and en=1 takes the bubble.
  - cnt_clr together with an increment condition yields 0.

Test Plan:
- Release rst_n, all en=1, ID feeds regw_addr_id=5, wb_wen_id=1 every cycle → if_valid=1 after edge 1, id_valid=1 after 2, exe_valid=1 with regw_addr_exe=5, wb_wen_exe=1 after 3, wb_valid=1 after 5; retire_cnt=1 at edge 6.
- LW to r8 in ID (is_load_id=1), then one stall cycle (if_en=id_en=0, exe_rst=1) → is_load_exe=1, regw_addr_exe=8 for one cycle, then an EXE bubble (exe_valid=0, wb_wen_exe=0) while is_load_mem=1, regw_addr_mem=8; bubble_cnt increments by 1; ID contents unchanged.
- SW with addr_rt_id=12, is_store_id=1 → addr_rt_mem=12 and is_store_mem=1 exactly two edges later; wb_wen_mem=0.
- Freeze all en=0 for 10 cycles mid-stream → every valid, field and counter unchanged; resumes identically afterwards.
- Drive rst_n low between clock edges with a full pipeline → all outputs 0 immediately; counters 0.
- CNT_W=4, run 17 enabled cycles → cycle_cnt wraps to 1. Assert cnt_clr in the same cycle as a retire → retire_cnt=0.

Source files
------------

// File: rtl/pipe_stage_tracker_if.sv
// Stage-control bundle between the pipeline controller and the pipeline registers.
// Latency: none (wires only).
// Backpressure: none; the controller's per-stage rst/en pairs are the only flow control.
interface pipe_stage_tracker_if #(
  parameter int CNT_W = 32
);
  // Controller -> pipeline registers: per-stage bubble/advance commands
  logic             if_rst,  if_en;
  logic             id_rst,  id_en;
  logic             exe_rst, exe_en;
  logic             mem_rst, mem_en;
  logic             wb_rst,  wb_en;

  // Decode results of the instruction currently in ID
  logic [4:0]       regw_addr_id;
  logic             wb_wen_id;
  logic             is_load_id;
  logic             is_store_id;
  logic [4:0]       addr_rt_id;

  logic             cnt_clr;

  // Stage occupancy and hazard feedback back to the controller
  logic             if_valid, id_valid, exe_valid, mem_valid, wb_valid;
  logic [4:0]       regw_addr_exe;
  logic             wb_wen_exe, is_load_exe, is_store_exe;
  logic [4:0]       regw_addr_mem;
  logic             wb_wen_mem, is_load_mem, is_store_mem;
  logic [4:0]       addr_rt_mem;
  logic [4:0]       regw_addr_wb;
  logic             wb_wen_wb;

  // Debug performance counters
  logic [CNT_W-1:0] cycle_cnt, retire_cnt, bubble_cnt;

  // Controller side
  modport master (
    output if_rst, if_en, id_rst, id_en, exe_rst, exe_en,
           mem_rst, mem_en, wb_rst, wb_en,
           regw_addr_id, wb_wen_id, is_load_id, is_store_id, addr_rt_id, cnt_clr,
    input  if_valid, id_valid, exe_valid, mem_valid, wb_valid,
           regw_addr_exe, wb_wen_exe, is_load_exe, is_store_exe,
           regw_addr_mem, wb_wen_mem, is_load_mem, is_store_mem, addr_rt_mem,
           regw_addr_wb, wb_wen_wb,
           cycle_cnt, retire_cnt, bubble_cnt
  );

  // Pipeline-register side
  modport slave (
    input  if_rst, if_en, id_rst, id_en, exe_rst, exe_en,
           mem_rst, mem_en, wb_rst, wb_en,
           regw_addr_id, wb_wen_id, is_load_id, is_store_id, addr_rt_id, cnt_clr,
    output if_valid, id_valid, exe_valid, mem_valid, wb_valid,
           regw_addr_exe, wb_wen_exe, is_load_exe, is_store_exe,
           regw_addr_mem, wb_wen_mem, is_load_mem, is_store_mem, addr_rt_mem,
           regw_addr_wb, wb_wen_wb,
           cycle_cnt, retire_cnt, bubble_cnt
  );
endinterface

// File: rtl/pipe_stage_tracker.sv
// Pipeline-register side of the 5-stage MIPS stage control: valid flags, hazard feedback, debug counters.
// Latency: ID fields reach EXE outputs 1 cycle after the edge, MEM 2, WB 3 (stages enabled).
// Backpressure: a stage with en=0 holds; rst=1 loads a bubble and wins over en.
module pipe_stage_tracker #(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipe_stage_tracker_if.slave  bus
);

  logic             if_valid_q,      if_valid_d;
  logic             id_valid_q,      id_valid_d;
  logic             exe_valid_q,     exe_valid_d;
  logic [4:0]       regw_addr_exe_q, regw_addr_exe_d;
  logic             wb_wen_exe_q,    wb_wen_exe_d;
  logic             is_load_exe_q,   is_load_exe_d;
  logic             is_store_exe_q,  is_store_exe_d;
  logic [4:0]       addr_rt_exe_q,   addr_rt_exe_d;
  logic             mem_valid_q,     mem_valid_d;
  logic [4:0]       regw_addr_mem_q, regw_addr_mem_d;
  logic             wb_wen_mem_q,    wb_wen_mem_d;
  logic             is_load_mem_q,   is_load_mem_d;
  logic             is_store_mem_q,  is_store_mem_d;
  logic [4:0]       addr_rt_mem_q,   addr_rt_mem_d;
  logic             wb_valid_q,      wb_valid_d;
  logic [4:0]       regw_addr_wb_q,  regw_addr_wb_d;
  logic             wb_wen_wb_q,     wb_wen_wb_d;
  logic [CNT_W-1:0] cycle_cnt_q,     cycle_cnt_d;
  logic [CNT_W-1:0] retire_cnt_q,    retire_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q,    bubble_cnt_d;

  // Stage next-state: bubble on rst, take upstream on en, otherwise hold
  always_comb begin
    if_valid_d      = if_valid_q;
    id_valid_d      = id_valid_q;
    exe_valid_d     = exe_valid_q;
    regw_addr_exe_d = regw_addr_exe_q;
    wb_wen_exe_d    = wb_wen_exe_q;
    is_load_exe_d   = is_load_exe_q;
    is_store_exe_d  = is_store_exe_q;
    addr_rt_exe_d   = addr_rt_exe_q;
    mem_valid_d     = mem_valid_q;
    regw_addr_mem_d = regw_addr_mem_q;
    wb_wen_mem_d    = wb_wen_mem_q;
    is_load_mem_d   = is_load_mem_q;
    is_store_mem_d  = is_store_mem_q;
    addr_rt_mem_d   = addr_rt_mem_q;
    wb_valid_d      = wb_valid_q;
    regw_addr_wb_d  = regw_addr_wb_q;
    wb_wen_wb_d     = wb_wen_wb_q;

    // Fetch always produces an instruction once running
    if (bus.if_rst)     if_valid_d = 1'b0;
    else if (bus.if_en) if_valid_d = 1'b1;

    if (bus.id_rst)     id_valid_d = 1'b0;
    else if (bus.id_en) id_valid_d = if_valid_q;

    // Side-effect flags are qualified with id_valid so an empty slot never
    // advertises a write or a load to the hazard logic
    if (bus.exe_rst) begin
      exe_valid_d     = 1'b0;
      regw_addr_exe_d = 5'd0;
      wb_wen_exe_d    = 1'b0;
      is_load_exe_d   = 1'b0;
      is_store_exe_d  = 1'b0;
      addr_rt_exe_d   = 5'd0;
    end else if (bus.exe_en) begin
      exe_valid_d     = id_valid_q;
      regw_addr_exe_d = bus.regw_addr_id;
      wb_wen_exe_d    = bus.wb_wen_id   & id_valid_q;
      is_load_exe_d   = bus.is_load_id  & id_valid_q;
      is_store_exe_d  = bus.is_store_id & id_valid_q;
      addr_rt_exe_d   = bus.addr_rt_id;
    end

    if (bus.mem_rst) begin
      mem_valid_d     = 1'b0;
      regw_addr_mem_d = 5'd0;
      wb_wen_mem_d    = 1'b0;
      is_load_mem_d   = 1'b0;
      is_store_mem_d  = 1'b0;
      addr_rt_mem_d   = 5'd0;
    end else if (bus.mem_en) begin
      mem_valid_d     = exe_valid_q;
      regw_addr_mem_d = regw_addr_exe_q;
      wb_wen_mem_d    = wb_wen_exe_q;
      is_load_mem_d   = is_load_exe_q;
      is_store_mem_d  = is_store_exe_q;
      addr_rt_mem_d   = addr_rt_exe_q;
    end

    if (bus.wb_rst) begin
      wb_valid_d     = 1'b0;
      regw_addr_wb_d = 5'd0;
      wb_wen_wb_d    = 1'b0;
    end else if (bus.wb_en) begin
      wb_valid_d     = mem_valid_q;
      regw_addr_wb_d = regw_addr_mem_q;
      wb_wen_wb_d    = wb_wen_mem_q;
    end
  end

  // Debug counters: clear wins; a stall bubble is exe_rst without mem_rst
  always_comb begin
    cycle_cnt_d  = cycle_cnt_q;
    retire_cnt_d = retire_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (bus.cnt_clr) begin
      cycle_cnt_d  = '0;
      retire_cnt_d = '0;
      bubble_cnt_d = '0;
    end else begin
      if (bus.wb_en)                             cycle_cnt_d  = cycle_cnt_q + CNT_W'(1);
      if (wb_valid_q && bus.wb_en && !bus.wb_rst) retire_cnt_d = retire_cnt_q + CNT_W'(1);
      if (bus.exe_rst && !bus.mem_rst)           bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  // State registers, cleared asynchronously by rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid_q      <= 1'b0;
      id_valid_q      <= 1'b0;
      exe_valid_q     <= 1'b0;
      regw_addr_exe_q <= 5'd0;
      wb_wen_exe_q    <= 1'b0;
      is_load_exe_q   <= 1'b0;
      is_store_exe_q  <= 1'b0;
      addr_rt_exe_q   <= 5'd0;
      mem_valid_q     <= 1'b0;
      regw_addr_mem_q <= 5'd0;
      wb_wen_mem_q    <= 1'b0;
      is_load_mem_q   <= 1'b0;
      is_store_mem_q  <= 1'b0;
      addr_rt_mem_q   <= 5'd0;
      wb_valid_q      <= 1'b0;
      regw_addr_wb_q  <= 5'd0;
      wb_wen_wb_q     <= 1'b0;
      cycle_cnt_q     <= '0;
      retire_cnt_q    <= '0;
      bubble_cnt_q    <= '0;
    end else begin
      if_valid_q      <= if_valid_d;
      id_valid_q      <= id_valid_d;
      exe_valid_q     <= exe_valid_d;
      regw_addr_exe_q <= regw_addr_exe_d;
      wb_wen_exe_q    <= wb_wen_exe_d;
      is_load_exe_q   <= is_load_exe_d;
      is_store_exe_q  <= is_store_exe_d;
      addr_rt_exe_q   <= addr_rt_exe_d;
      mem_valid_q     <= mem_valid_d;
      regw_addr_mem_q <= regw_addr_mem_d;
      wb_wen_mem_q    <= wb_wen_mem_d;
      is_load_mem_q   <= is_load_mem_d;
      is_store_mem_q  <= is_store_mem_d;
      addr_rt_mem_q   <= addr_rt_mem_d;
      wb_valid_q      <= wb_valid_d;
      regw_addr_wb_q  <= regw_addr_wb_d;
      wb_wen_wb_q     <= wb_wen_wb_d;
      cycle_cnt_q     <= cycle_cnt_d;
      retire_cnt_q    <= retire_cnt_d;
      bubble_cnt_q    <= bubble_cnt_d;
    end
  end

  assign bus.if_valid      = if_valid_q;
  assign bus.id_valid      = id_valid_q;
  assign bus.exe_valid     = exe_valid_q;
  assign bus.regw_addr_exe = regw_addr_exe_q;
  assign bus.wb_wen_exe    = wb_wen_exe_q;
  assign bus.is_load_exe   = is_load_exe_q;
  assign bus.is_store_exe  = is_store_exe_q;
  assign bus.mem_valid     = mem_valid_q;
  assign bus.regw_addr_mem = regw_addr_mem_q;
  assign bus.wb_wen_mem    = wb_wen_mem_q;
  assign bus.is_load_mem   = is_load_mem_q;
  assign bus.is_store_mem  = is_store_mem_q;
  assign bus.addr_rt_mem   = addr_rt_mem_q;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.regw_addr_wb  = regw_addr_wb_q;
  assign bus.wb_wen_wb     = wb_wen_wb_q;
  assign bus.cycle_cnt     = cycle_cnt_q;
  assign bus.retire_cnt    = retire_cnt_q;
  assign bus.bubble_cnt    = bubble_cnt_q;

endmodule
